// File: rtl/jtframe_sdram_rrarb.sv
// jtframe_sdram_rrarb: round-robin arbiter sharing one SDRAM controller port among four clients,
// sequencing request/ack/data_rdy per access with an optional abort watchdog.
module jtframe_sdram_rrarb #(
  parameter int SDRAMW  = 22,
  parameter int PRIO0   = 0,
  parameter int TIMEOUT = 0,
  parameter int TOW     = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            cl_rd,
  input  logic [3:0]            cl_wr,
  input  logic [4*SDRAMW-1:0]   cl_addr,
  input  logic [63:0]           cl_din,
  input  logic [7:0]            cl_wrmask,
  output logic [3:0]            cl_ack,
  output logic [3:0]            cl_rdy,
  output logic [31:0]           cl_dout,
  output logic                  err,
  output logic [1:0]            err_id,
  output logic                  busy,
  output logic                  sdram_rd,
  output logic                  sdram_wr,
  output logic [SDRAMW-1:0]     sdram_addr,
  output logic [15:0]           data_write,
  output logic [1:0]            sdram_wrmask,
  input  logic                  sdram_ack,
  input  logic                  data_rdy,
  input  logic [31:0]           data_read
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  localparam logic [TOW-1:0] TO_LAST = TOW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  state_t r_state, w_next;
  logic [1:0] r_ptr, r_gnt, r_err_id, w_win;
  logic [3:0] r_ack, r_rdy, w_req;
  logic [31:0] r_dout;
  logic r_err, r_rd, r_wr, r_op_wr;
  logic [SDRAMW-1:0] r_addr, w_addr;
  logic [15:0] r_din, w_din;
  logic [1:0] r_mask, w_mask;
  logic [TOW-1:0] r_cnt;
  logic w_done, w_to, w_acked, w_grant;
  assign w_req = cl_rd | cl_wr;
  // Descending scan so the last hit is the closest one at or after r_ptr
  always_comb begin
    w_win  = r_ptr;
    w_addr = '0;
    w_din  = '0;
    w_mask = 2'b11;
    for (int k = 3; k >= 0; k--)
      if (w_req[r_ptr + 2'(k)]) w_win = r_ptr + 2'(k);
    if (PRIO0 != 0 && w_req[0]) w_win = 2'd0;
    for (int k = 0; k < 4; k++)
      if (w_win == 2'(k)) begin
        w_addr = cl_addr[k*SDRAMW +: SDRAMW];
        w_din  = cl_din[k*16 +: 16];
        w_mask = cl_wrmask[k*2 +: 2];
      end
  end
  always_comb begin
    w_grant = r_state == IDLE && |w_req;
    w_done  = (r_state == ISSUE && sdram_ack && data_rdy) || (r_state == WAIT && data_rdy);
    w_to    = TIMEOUT != 0 && r_state != IDLE && !w_done && r_cnt == TO_LAST;
    w_acked = r_state == ISSUE && sdram_ack && !w_to;
    w_next  = r_state;
    if (r_state == IDLE) w_next = w_grant ? ISSUE : IDLE;
    else if (w_done || w_to) w_next = IDLE;
    else if (r_state == ISSUE && sdram_ack) w_next = WAIT;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr    <= '0;
      r_gnt    <= '0;
      r_ack    <= '0;
      r_rdy    <= '0;
      r_dout   <= '0;
      r_err    <= 1'b0;
      r_err_id <= '0;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_op_wr  <= 1'b0;
      r_addr   <= '0;
      r_din    <= '0;
      r_mask   <= 2'b11;
      r_cnt    <= '0;
    end else begin
      r_ack <= w_acked ? 4'b1 << r_gnt : 4'b0;
      r_rdy <= w_done ? 4'b1 << r_gnt : 4'b0;
      r_err <= w_to;
      r_cnt <= r_state == IDLE ? '0 : r_cnt + 1'b1;
      if (w_to) r_err_id <= r_gnt;
      if (w_done && !r_op_wr) r_dout <= data_read;
      if (w_acked || w_to || w_done) r_ptr <= r_gnt + 2'd1;
      if (w_acked || w_to) begin
        r_rd <= 1'b0;
        r_wr <= 1'b0;
      end
      if (w_grant) begin
        r_gnt   <= w_win;
        r_addr  <= w_addr;
        r_din   <= w_din;
        r_wr    <= cl_wr[w_win];
        r_rd    <= ~cl_wr[w_win];
        r_op_wr <= cl_wr[w_win];
        r_mask  <= cl_wr[w_win] ? w_mask : 2'b11;
      end
    end
  end
  assign cl_ack       = r_ack;
  assign cl_rdy       = r_rdy;
  assign cl_dout      = r_dout;
  assign err          = r_err;
  assign err_id       = r_err_id;
  assign busy         = r_state != IDLE;
  assign sdram_rd     = r_rd;
  assign sdram_wr     = r_wr;
  assign sdram_addr   = r_addr;
  assign data_write   = r_din;
  assign sdram_wrmask = r_mask;
endmodule

// File: doc/jtframe_sdram_rrarb.md
Name: jtframe_sdram_rrarb

Overview:
Round-robin arbiter that shares one SDRAM controller port among four bus clients, each a slot-group manager with its own rd/wr request. It sits between several slot managers and the SDRAM controller. It sequences each access as request, controller ack, then data_rdy, and it routes the handshakes back to the winning client. A watchdog aborts accesses that the controller never completes.

Parameters:
SDRAMW, 22, SDRAM word-address width
PRIO0, 0, 1 = client 0 has fixed top priority; the other clients rotate round-robin
TIMEOUT, 0, cycles allowed from grant to data_rdy before abort; 0 disables the watchdog
TOW, 10, watchdog counter width; TIMEOUT must be < 2**TOW

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
cl_rd  in  4  per-client read request, level, held until cl_ack
cl_wr  in  4  per-client write request, level, held until cl_ack
cl_addr  in  4*SDRAMW  packed addresses; client i uses bits [i*SDRAMW +: SDRAMW]
cl_din  in  64  packed 16-bit write data; client i uses [i*16 +: 16]
cl_wrmask  in  8  packed 2-bit byte masks, active low
cl_ack  out  4  one-cycle pulse: request accepted by the controller
cl_rdy  out  4  one-cycle pulse: access complete, cl_dout valid
cl_dout  out  32  last read data, shared by all clients
err  out  1  one-cycle pulse on watchdog abort
err_id  out  2  index of the aborted client, held until the next abort
busy  out  1  high in ISSUE or WAIT
sdram_rd  out  1  read request to the controller
sdram_wr  out  1  write request to the controller
sdram_addr  out  SDRAMW  latched address
data_write  out  16  latched write data
sdram_wrmask  out  2  latched mask, active low
sdram_ack  in  1  controller accepted the command
data_rdy  in  1  controller finished the access (reads and writes)
data_read  in  32  controller read data

Behaviour:
- Reset (asynchronous): state=IDLE, ptr=0, all outputs 0 except sdram_wrmask=2'b11, watchdog counter=0, err_id=0.
- req[i] = cl_rd[i] | cl_wr[i]. Requests are sampled only in IDLE. If a client drops its request before it is granted, nothing is issued for it.
- IDLE: if req≠0, pick the winner.
  - If PRIO0=1 and req[0]=1, the winner is client 0.
  - Otherwise the winner is the first set bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - Next edge: latch the winner's addr, din and wrmask; set sdram_wr=cl_wr[w] and sdram_rd=~cl_wr[w] (wr wins if both are set); gnt=w; state=ISSUE.
  - Write transactions drive the client mask. Reads drive sdram_wrmask=2'b11.
- ISSUE: hold sdram_rd/sdram_wr and the latched fields stable until sdram_ack=1.
  - On the ack edge: drop sdram_rd/sdram_wr, pulse cl_ack[gnt], set ptr=gnt+1 (mod 4), state=WAIT.
  - If data_rdy and sdram_ack arrive in the same cycle, treat both: go straight to completion (see WAIT) with a single cl_ack and a single cl_rdy.
- WAIT: on data_rdy, register cl_dout<=data_read and pulse cl_rdy[gnt] on the next cycle; state=IDLE.
  - cl_dout updates only on read completions. Writes pulse cl_rdy but leave cl_dout unchanged.
- Latency: a new grant can issue the cycle after returning to IDLE, so back-to-back accesses have a one-cycle IDLE gap.
- A data_rdy that arrives in IDLE is ignored: no cl_rdy pulse, cl_dout unchanged.
- Watchdog (TIMEOUT>0):
  - The counter clears on grant and increments every cycle in ISSUE or WAIT.
  - When it reaches TIMEOUT without completion: drop sdram_rd/sdram_wr, pulse err, set err_id=gnt, no cl_rdy, ptr=gnt+1, state=IDLE.
  - If data_rdy coincides with the timeout cycle, completion wins and err is not raised.
- At most one bit of cl_ack and one bit of cl_rdy is set in any cycle. cl_ack and cl_rdy are never set to a client other than gnt.
- Asserting rst mid-access drops all requests immediately. The controller must be reset alongside the arbiter.

Test Plan:
- Single read: client 2 reads addr 0x1234, controller acks 2 cycles after request and data_rdy 4 cycles after ack with 0xCAFEBABE -> sdram_rd=1 with addr 0x1234; cl_ack[2] pulses; cl_rdy[2] pulses with cl_dout=0xCAFEBABE; err stays 0.
- Round-robin: all four clients request continuously with PRIO0=0 -> grant order 0,1,2,3,0; no client granted twice before the others are served.
- PRIO0=1: clients 0 and 3 request continuously -> client 0 wins every arbitration until it drops; client 3 is granted in the first IDLE where cl_rd[0]=cl_wr[0]=0.
- Write: client 1 writes din=0xA55A, mask=2'b01 -> sdram_wr=1, data_write=0xA55A, sdram_wrmask=2'b01; cl_rdy[1] pulses; cl_dout unchanged.
- Watchdog: TIMEOUT=8, controller acks but never asserts data_rdy -> err pulses 8 cycles after grant, err_id=gnt, cl_rdy stays 0, arbiter grants the next requester.
- Same-cycle ack+data_rdy, plus rst asserted mid-WAIT -> one cl_ack and one cl_rdy for the coincident case; after rst all outputs are at reset values within the same cycle, with no rdy pulse afterwards.
